// File: rtl/obi_sbr_regfile.sv
// -----------------------------------------------------------------------------
// obi_sbr_regfile
//
// OBI v1.1 subordinate that exposes a small word-addressed register file on
// the A and R channels. Each accepted transfer yields exactly one response,
// queued in acceptance order through a small response FIFO.
//
// Handshake semantics (both channels are strict valid/ready):
//   A channel: a transfer is accepted on a rising edge where
//              obi_req_i && obi_gnt_o. obi_gnt_o is purely a function of
//              stall_i and FIFO occupancy; it never looks at obi_req_i or
//              obi_rready_i, so a slot freed by a pop is reusable only from
//              the following cycle.
//   R channel: a response is consumed on a rising edge where
//              obi_rvalid_o && obi_rready_i. While obi_rvalid_o is high and
//              obi_rready_i is low, rdata/err stay stable.
//
// Ports
//   clk_i         clock, all state on rising edge
//   reset_ni      asynchronous active-low reset
//   obi_req_i     A-channel request
//   obi_gnt_o     A-channel grant
//   obi_addr_i    byte address
//   obi_we_i      1 = write, 0 = read
//   obi_be_i      byte enables (writes only)
//   obi_wdata_i   write data
//   obi_rvalid_o  R-channel valid (response FIFO non-empty)
//   obi_rready_i  R-channel ready
//   obi_rdata_o   read data of the FIFO head, 0 when empty
//   obi_err_o     error flag of the FIFO head, 0 when empty
//   stall_i       forces grant low (backpressure hook)
//   err_cnt_o     saturating count of error responses issued
// -----------------------------------------------------------------------------
module obi_sbr_regfile #(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           NUM_WORDS  = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int unsigned           RSP_DEPTH  = 2
) (
   input  logic                    clk_i,
   input  logic                    reset_ni,
   input  logic                    obi_req_i,
   output logic                    obi_gnt_o,
   input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
   input  logic                    obi_we_i,
   input  logic [DATA_WIDTH/8-1:0] obi_be_i,
   input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
   output logic                    obi_rvalid_o,
   input  logic                    obi_rready_i,
   output logic [DATA_WIDTH-1:0]   obi_rdata_o,
   output logic                    obi_err_o,
   input  logic                    stall_i,
   output logic [7:0]              err_cnt_o
);

   localparam int unsigned BE_W    = DATA_WIDTH / 8;
   localparam int unsigned OFF_LSB = $clog2(BE_W);
   localparam int unsigned IDX_W   = $clog2(NUM_WORDS);
   localparam int unsigned PTR_W   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int unsigned CNT_W   = $clog2(RSP_DEPTH + 1);

   localparam logic [ADDR_WIDTH-1:0] SPAN     = ADDR_WIDTH'(NUM_WORDS * BE_W);
   localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(RSP_DEPTH - 1);
   localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(RSP_DEPTH);

   // Storage
   logic [DATA_WIDTH-1:0] r_mem      [NUM_WORDS];
   logic [DATA_WIDTH-1:0] r_rsp_data [RSP_DEPTH];
   logic [RSP_DEPTH-1:0]  r_rsp_err;
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;
   logic [7:0]            r_err_cnt;

   // Decode / handshake
   logic [ADDR_WIDTH-1:0] w_offset;
   logic                  w_misalign;
   logic                  w_out_of_range;
   logic                  w_dec_err;
   logic [IDX_W-1:0]      w_index;
   logic                  w_accept;
   logic                  w_rvalid;
   logic                  w_pop;
   logic                  w_wr_ok;
   logic [DATA_WIDTH-1:0] w_push_data;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // Modular subtraction makes addresses below BASE_ADDR wrap to large
   // offsets, so a single unsigned range check catches both sides.
   assign w_offset       = obi_addr_i - BASE_ADDR;
   assign w_misalign     = |w_offset[OFF_LSB-1:0];
   assign w_out_of_range = (w_offset >= SPAN);
   assign w_dec_err      = w_misalign || w_out_of_range;
   assign w_index        = w_offset[OFF_LSB +: IDX_W];

   assign obi_gnt_o = !stall_i && (r_count < CNT_FULL);
   assign w_accept  = obi_req_i && obi_gnt_o;
   assign w_rvalid  = (r_count != '0);
   assign w_pop     = w_rvalid && obi_rready_i;
   assign w_wr_ok   = w_accept && obi_we_i && !w_dec_err;

   // Reads capture the array before this edge's write; writes and errors
   // return zero data.
   assign w_push_data = (obi_we_i || w_dec_err) ? '0 : r_mem[w_index];

   // Register file
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         for (int i = 0; i < int'(NUM_WORDS); i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wr_ok) begin
         for (int k = 0; k < int'(BE_W); k++) begin
            if (obi_be_i[k]) begin
               r_mem[w_index][8*k +: 8] <= obi_wdata_i[8*k +: 8];
            end
         end
      end
   end

   // Response FIFO storage: contents are only observable through the
   // pointers, so no reset is needed here.
   always_ff @(posedge clk_i) begin
      if (w_accept) begin
         r_rsp_data[r_wr_ptr] <= w_push_data;
         r_rsp_err[r_wr_ptr]  <= w_dec_err;
      end
   end

   // Response FIFO control
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_accept) begin
            r_wr_ptr <= ptr_inc(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Error counter, saturating at 8'hFF
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_err_cnt <= '0;
      end else if (w_accept && w_dec_err && (r_err_cnt != 8'hFF)) begin
         r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   assign obi_rvalid_o = w_rvalid;
   assign obi_rdata_o  = w_rvalid ? r_rsp_data[r_rd_ptr] : '0;
   assign obi_err_o    = w_rvalid && r_rsp_err[r_rd_ptr];
   assign err_cnt_o    = r_err_cnt;

endmodule

// File: tb/tb_obi_sbr_regfile.sv
// -----------------------------------------------------------------------------
// tb_obi_sbr_regfile
//
// Directed scenarios followed by randomized traffic for obi_sbr_regfile.
// Expected responses come from a transaction-level model: a word array, a
// queue of outstanding {err, rdata} responses and an error counter. Inputs
// change on the falling edge; outputs are compared 1 ns later, well before
// the next rising edge.
// -----------------------------------------------------------------------------
module tb_obi_sbr_regfile;

   localparam int unsigned    NWORDS = 16;
   localparam int unsigned    DEPTH  = 2;
   localparam logic [31:0]    BASE   = 32'h0000_0100;

   // ---------------------------------------------------------------- clock/reset
   logic        clk = 1'b0;
   logic        reset_ni;
   always #5 clk = ~clk;

   logic        obi_req_i;
   logic        obi_gnt_o;
   logic [31:0] obi_addr_i;
   logic        obi_we_i;
   logic [3:0]  obi_be_i;
   logic [31:0] obi_wdata_i;
   logic        obi_rvalid_o;
   logic        obi_rready_i;
   logic [31:0] obi_rdata_o;
   logic        obi_err_o;
   logic        stall_i;
   logic [7:0]  err_cnt_o;

   obi_sbr_regfile #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .NUM_WORDS  (NWORDS),
      .BASE_ADDR  (BASE),
      .RSP_DEPTH  (DEPTH)
   ) dut (
      .clk_i        (clk),
      .reset_ni     (reset_ni),
      .obi_req_i    (obi_req_i),
      .obi_gnt_o    (obi_gnt_o),
      .obi_addr_i   (obi_addr_i),
      .obi_we_i     (obi_we_i),
      .obi_be_i     (obi_be_i),
      .obi_wdata_i  (obi_wdata_i),
      .obi_rvalid_o (obi_rvalid_o),
      .obi_rready_i (obi_rready_i),
      .obi_rdata_o  (obi_rdata_o),
      .obi_err_o    (obi_err_o),
      .stall_i      (stall_i),
      .err_cnt_o    (err_cnt_o)
   );

   // ---------------------------------------------------------------- model
   logic [31:0] m_mem [NWORDS];
   logic [32:0] exp_q [$];          // {err, rdata}
   int          m_err_cnt;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      for (int i = 0; i < int'(NWORDS); i++) m_mem[i] = 32'h0;
      m_err_cnt = 0;
   endtask

   // One bus cycle: drive inputs, compare all outputs against the model,
   // then advance the model by what the coming rising edge does.
   task automatic step(input logic req, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wdata,
                       input logic rready, input logic stall);
      logic        exp_gnt;
      logic [32:0] head;
      logic [31:0] off;
      logic        bad;
      int          idx;
      @(negedge clk);
      obi_req_i    = req;
      obi_we_i     = we;
      obi_addr_i   = addr;
      obi_be_i     = be;
      obi_wdata_i  = wdata;
      obi_rready_i = rready;
      stall_i      = stall;
      #1;
      exp_gnt = !stall && (exp_q.size() < int'(DEPTH));
      head    = (exp_q.size() > 0) ? exp_q[0] : 33'h0;
      chk("gnt",     64'(obi_gnt_o),    64'(exp_gnt));
      chk("rvalid",  64'(obi_rvalid_o), 64'(exp_q.size() > 0));
      chk("rdata",   64'(obi_rdata_o),  64'(head[31:0]));
      chk("err",     64'(obi_err_o),    64'(head[32]));
      chk("err_cnt", 64'(err_cnt_o),    64'(m_err_cnt));
      if (reset_ni) begin
         if (rready && exp_q.size() > 0) void'(exp_q.pop_front());
         if (req && exp_gnt) begin
            off = addr - BASE;
            bad = ((off % 4) != 0) || (off >= NWORDS * 4);
            idx = int'(off / 4);
            if (bad) begin
               exp_q.push_back({1'b1, 32'h0});
               if (m_err_cnt < 255) m_err_cnt++;
            end else if (we) begin
               for (int k = 0; k < 4; k++)
                  if (be[k]) m_mem[idx][8*k +: 8] = wdata[8*k +: 8];
               exp_q.push_back({1'b0, 32'h0});
            end else begin
               exp_q.push_back({1'b0, m_mem[idx]});
            end
         end
      end
   endtask

   task automatic idle(input logic rready);
      step(1'b0, 1'b0, BASE, 4'h0, 32'h0, rready, 1'b0);
   endtask

   task automatic rd(input logic [31:0] addr, input logic rready);
      step(1'b1, 1'b0, addr, 4'h0, 32'h0, rready, 1'b0);
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] be, input logic rready);
      step(1'b1, 1'b1, addr, be, data, rready, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rvalid"},  64'(obi_rvalid_o), 64'h0);
      chk({tag, "_rdata"},   64'(obi_rdata_o),  64'h0);
      chk({tag, "_err"},     64'(obi_err_o),    64'h0);
      chk({tag, "_err_cnt"}, 64'(err_cnt_o),    64'h0);
      chk({tag, "_gnt"},     64'(obi_gnt_o),    64'(!stall_i));
   endtask

   // ---------------------------------------------------------------- watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      logic [31:0] a;
      int          kind;
      reset_ni     = 1'b0;
      obi_req_i    = 1'b0;
      obi_we_i     = 1'b0;
      obi_addr_i   = BASE;
      obi_be_i     = 4'h0;
      obi_wdata_i  = 32'h0;
      obi_rready_i = 1'b0;
      stall_i      = 1'b0;
      model_clear();

      repeat (2) @(negedge clk);
      #1;
      check_reset_outputs("por");
      @(negedge clk);
      reset_ni = 1'b1;

      // Full-word write then read-back.
      wr(BASE + 32'h4, 32'hDEADBEEF, 4'hF, 1'b1);
      rd(BASE + 32'h4, 1'b1);
      idle(1'b1);
      chk("t1_rdata", 64'(obi_rdata_o), 64'hDEADBEEF);
      chk("t1_err",   64'(obi_err_o),   64'h0);

      // Partial byte-enable write merges with the old word.
      wr(BASE + 32'h4, 32'h11223344, 4'b0101, 1'b1);
      rd(BASE + 32'h4, 1'b1);
      idle(1'b1);
      chk("t2_merge", 64'(obi_rdata_o), 64'hDE22BE44);

      // Misaligned and past-the-end accesses.
      rd(BASE + 32'h2, 1'b1);
      rd(BASE + NWORDS * 4, 1'b1);
      chk("t3_err1",  64'(obi_err_o),   64'h1);
      chk("t3_rd1",   64'(obi_rdata_o), 64'h0);
      idle(1'b1);
      chk("t3_err2",  64'(obi_err_o),   64'h1);
      chk("t3_cnt",   64'(err_cnt_o),   64'h2);
      rd(BASE + 32'h4, 1'b1);
      idle(1'b1);
      chk("t3_keep",  64'(obi_rdata_o), 64'hDE22BE44);

      // FIFO full with rready low; third grant only after the first pop.
      rd(BASE + 32'h0, 1'b0);
      rd(BASE + 32'h4, 1'b0);
      rd(BASE + 32'h8, 1'b0);
      chk("t4_full_gnt", 64'(obi_gnt_o), 64'h0);
      rd(BASE + 32'h8, 1'b0);
      rd(BASE + 32'h8, 1'b1);
      chk("t4_pop_gnt",  64'(obi_gnt_o),   64'h0);
      chk("t4_first",    64'(obi_rdata_o), 64'h0);
      rd(BASE + 32'h8, 1'b1);
      chk("t4_regnt",    64'(obi_gnt_o),   64'h1);
      chk("t4_second",   64'(obi_rdata_o), 64'hDE22BE44);
      idle(1'b1);
      chk("t4_third",    64'(obi_rvalid_o), 64'h1);

      // Stall suppresses grant.
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, BASE + 32'h4, 4'h0, 32'h0, 1'b1, 1'b1);
         chk("t5_stall_gnt", 64'(obi_gnt_o),    64'h0);
         chk("t5_stall_rv",  64'(obi_rvalid_o), 64'h0);
      end
      rd(BASE + 32'h4, 1'b1);
      chk("t5_gnt", 64'(obi_gnt_o), 64'h1);
      idle(1'b1);
      chk("t5_rsp", 64'(obi_rdata_o), 64'hDE22BE44);

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         kind = int'($urandom_range(0, 9));
         if (kind <= 6)      a = BASE + 32'(4 * $urandom_range(0, NWORDS - 1));
         else if (kind == 7) a = BASE + 32'(4 * $urandom_range(0, NWORDS - 1)) + 32'($urandom_range(1, 3));
         else if (kind == 8) a = BASE + 32'(NWORDS * 4) + 32'(4 * $urandom_range(0, 20));
         else                a = BASE - 32'(4 * $urandom_range(1, 8));
         step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a,
              4'($urandom_range(0, 15)), $urandom,
              $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
      end
      repeat (3) idle(1'b1);

      // Saturate the error counter.
      for (int n = 0; n < 260; n++) rd(BASE + 32'h1, 1'b1);
      idle(1'b1);
      chk("sat_cnt", 64'(err_cnt_o), 64'hFF);
      idle(1'b1);

      // Reset while responses are outstanding.
      rd(BASE + 32'h2, 1'b0);
      wr(BASE + 32'h8, 32'h5555_AAAA, 4'hF, 1'b0);
      idle(1'b1);
      chk("t6_mid_rv", 64'(obi_rvalid_o), 64'h1);
      @(negedge clk);
      reset_ni = 1'b0;
      #1;
      model_clear();
      check_reset_outputs("t6_rst");
      rd(BASE + 32'h8, 1'b1);     // ignored while in reset
      idle(1'b1);
      chk("t6_ignored", 64'(obi_rvalid_o), 64'h0);
      @(negedge clk);
      reset_ni = 1'b1;
      rd(BASE + 32'h8, 1'b1);
      rd(BASE + 32'h4, 1'b1);
      chk("t6_clr8", 64'(obi_rdata_o), 64'h0);
      chk("t6_v8",   64'(obi_rvalid_o), 64'h1);
      idle(1'b1);
      chk("t6_clr4", 64'(obi_rdata_o), 64'h0);
      chk("t6_v4",   64'(obi_rvalid_o), 64'h1);
      idle(1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
